mem_access_stage: RTL
=====================

# mem_access_stage

MIPS pipeline MEM stage: consumes the EX/MEM register outputs, runs a req/ack data-memory transaction for loads and stores, and drives the MEM/WB pipeline register feeding write-back. While a memory transaction is outstanding it stalls the upstream stages and inserts bubbles into MEM/WB. It also flags misaligned word accesses and bus timeouts.

## Interface
- TIMEOUT, 16: maximum cycles in ACCESS without `dmem_ack` before abort; legal range 2..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  RegWrite from EX/MEM.
- mem_r_en_in  in  1  MemRead from EX/MEM.
- mem_w_en_in  in  1  MemWrite from EX/MEM.
- pc_in  in  32  instruction PC.
- alu_res_in  in  32  ALU result; byte address for memory ops.
- st_val_in  in  32  store data.
- dest_in  in  5  destination register.
- dmem_req  out  1  registered memory request, held until ack or abort.
- dmem_we  out  1  registered; 1 = write.
- dmem_addr  out  32  registered word address, `{alu_res_in[31:2],2'b00}`.
- dmem_wdata  out  32  registered store data.
- dmem_rdata  in  32  read data, valid when `dmem_ack` is 1.
- dmem_ack  in  1  one-cycle completion strobe.
- stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM.
- wb_en_out  out  1  MEM/WB RegWrite.
- mem_r_en_out  out  1  MEM/WB MemToReg select.
- pc_out, alu_res_out, mem_data_out  out  32 each  MEM/WB payload.
- dest_out  out  5  MEM/WB destination.
- misalign_err  out  1  one-cycle registered pulse.
- bus_err  out  1  one-cycle registered pulse.

## Operation
- Reset: state IDLE; every output register, including `dmem_*`, the MEM/WB fields, the error pulses and the timeout counter, is 0.
- `mem_op` = `mem_r_en_in | mem_w_en_in`. If both are 1, treat the op as a read.
- `mis` = `mem_op & (alu_res_in[1:0] != 0)`.
- FSM states are IDLE and ACCESS.
- **IDLE, no `mem_op`:**
  - MEM/WB loads the inputs; `mem_data_out` = 0.
  - Single-cycle pass-through; `stall` = 0.
- **IDLE, `mis`:**
  - No request is issued; `stall` = 0.
  - MEM/WB loads `pc`, `alu_res` and `dest`, with `wb_en_out` = 0 and `mem_r_en_out` = 0.
  - `misalign_err` = 1 for one cycle.
- **IDLE, aligned `mem_op`:**
  - `stall` = 1; MEM/WB loads a bubble (all fields 0).
  - At the clock edge: `dmem_req` = 1, `dmem_we` = `mem_w_en_in & ~mem_r_en_in`, address and wdata are latched, counter = 0, and the FSM goes to ACCESS.
- **ACCESS, `dmem_ack` = 1:**
  - `stall` = 0.
  - MEM/WB loads the inputs, which EX/MEM is still holding. `mem_data_out` = `dmem_rdata` for a read and 0 for a write.
  - `dmem_req` goes to 0 and the FSM returns to IDLE.
- **ACCESS, no ack, counter = TIMEOUT-1:**
  - `stall` = 0.
  - MEM/WB loads the inputs with `wb_en_out` = 0, `mem_r_en_out` = 0 and `mem_data_out` = 0.
  - `bus_err` pulses; `dmem_req` goes to 0; the FSM returns to IDLE.
- **ACCESS, otherwise:** `stall` = 1, MEM/WB loads a bubble, and the counter increments (8-bit, saturating).
- **Precedence:** ack in the same cycle as the timeout completes the access normally (ack wins).
- `dmem_ack` in IDLE is ignored.
- `dmem_addr` and `dmem_wdata` stay stable while `dmem_req` = 1.
- An asynchronous reset mid-ACCESS drops `dmem_req` immediately and discards the access. No error pulse is generated.

## Timing
- Non-memory and misaligned instructions: 1 cycle in the stage; MEM/WB is valid the cycle after entry.
- Memory op with ack N cycles after `dmem_req` rises (N ≥ 0):
  - `stall` is high for N+1 cycles.
  - The instruction occupies the stage for N+2 cycles.
  - The result is in MEM/WB the cycle after ack.
- Zero-wait memory (ack in the first cycle of `dmem_req`): `stall` is high for exactly 1 cycle.
- Timeout: `dmem_req` is high for exactly TIMEOUT cycles; `bus_err` asserts in the cycle after the last of them.
- Back-to-back memory ops: the next `dmem_req` rises 2 cycles after the previous ack, because IDLE is always visited for at least 1 cycle.
- `stall` is combinational from state, inputs and `dmem_ack`. It has no path from any MEM/WB output.

## Test plan
- **Reset and ALU op:**
  - Stimulus: reset, then release. ALU op with `wb_en_in`=1, `alu_res_in`=0x0000_1234, `dest_in`=5, `pc_in`=0x40.
  - Response: all outputs 0 during reset. Next cycle `wb_en_out`=1, `alu_res_out`=0x1234, `dest_out`=5, `pc_out`=0x40, `stall` never high.
- **Load with 3 wait cycles:**
  - Stimulus: `mem_r_en_in`=1, `wb_en_in`=1, `alu_res_in`=0x100; ack on the 4th cycle of `dmem_req` with `dmem_rdata`=0xDEADBEEF.
  - Response: `stall` high for 4 cycles. `dmem_addr`=0x100, `dmem_we`=0. Bubbles in MEM/WB meanwhile, then `mem_data_out`=0xDEADBEEF, `mem_r_en_out`=1, `wb_en_out`=1.
- **Zero-wait store:**
  - Stimulus: `mem_w_en_in`=1, `st_val_in`=0xA5A5A5A5, `alu_res_in`=0x204; ack in the first `dmem_req` cycle.
  - Response: `dmem_we`=1, `dmem_wdata`=0xA5A5A5A5, `stall` high for 1 cycle, `wb_en_out`=0, `mem_data_out`=0.
- **Misaligned load:**
  - Stimulus: load with `alu_res_in`=0x102.
  - Response: `dmem_req` never rises, `stall`=0, `misalign_err` pulses 1 cycle, `wb_en_out`=0.
- **Timeout:**
  - Stimulus: TIMEOUT=4, load, no ack; then repeat with ack on the 4th cycle.
  - Response: first run, `dmem_req` high 4 cycles, `bus_err` pulses, `wb_en_out`=0. Second run completes normally and `bus_err` stays 0.
- **Reset mid-access:**
  - Stimulus: assert `rst_n`=0 during ACCESS, away from any clock edge.
  - Response: `dmem_req`, `stall` and all outputs go to 0 immediately. After release, a new ALU op passes in 1 cycle.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master)
// and the data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs req/ack data-memory transactions for loads/stores,
// stalls the front of the pipe while a transaction is outstanding, fills
// MEM/WB (with bubbles while waiting) and flags misaligned/timed-out accesses.
module mem_access_stage #(
    parameter int TIMEOUT = 16          // legal range 2..255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_en_in,
    input  logic                      mem_r_en_in,
    input  logic                      mem_w_en_in,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               alu_res_in,
    input  logic [31:0]               st_val_in,
    input  logic [4:0]                dest_in,
    mem_access_stage_if.master        dmem,
    output logic                      stall,
    output logic                      wb_en_out,
    output logic                      mem_r_en_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               alu_res_out,
    output logic [31:0]               mem_data_out,
    output logic [4:0]                dest_out,
    output logic                      misalign_err,
    output logic                      bus_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wb_q;
    logic        mr_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] data_q;
    logic [4:0]  dest_q;
    logic        misalign_q;
    logic        buserr_q;

    logic mem_op;
    logic mis;
    logic go_access;
    logic last_wait;

    assign mem_op    = mem_r_en_in | mem_w_en_in;
    assign mis       = mem_op & (alu_res_in[1:0] != 2'b00);
    assign go_access = mem_op & ~mis;
    assign last_wait = (cnt_q == CNT_LAST);

    // Stall is purely a function of state, EX/MEM inputs and ack; it is
    // held low while reset is asserted so the front end never freezes then.
    assign stall = rst_n & ((state_q == S_IDLE) ? go_access
                                                : (~dmem.dmem_ack & ~last_wait));

    // Single FSM: bus request/address/data registers, wait counter, MEM/WB
    // payload and error pulses all update together on each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wb_q       <= 1'b0;
            mr_q       <= 1'b0;
            pc_q       <= 32'd0;
            alu_q      <= 32'd0;
            data_q     <= 32'd0;
            dest_q     <= 5'd0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            // Default MEM/WB load: payload passes, control cleared, no pulses.
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            pc_q       <= pc_in;
            alu_q      <= alu_res_in;
            dest_q     <= dest_in;
            wb_q       <= 1'b0;
            mr_q       <= 1'b0;
            data_q     <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (!mem_op) begin
                        wb_q <= wb_en_in;
                    end else if (mis) begin
                        misalign_q <= 1'b1;
                    end else begin
                        pc_q    <= 32'd0;
                        alu_q   <= 32'd0;
                        dest_q  <= 5'd0;
                        req_q   <= 1'b1;
                        we_q    <= mem_w_en_in & ~mem_r_en_in;
                        addr_q  <= {alu_res_in[31:2], 2'b00};
                        wdata_q <= st_val_in;
                        cnt_q   <= 8'd0;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ack takes precedence over an expiring timeout.
                    if (dmem.dmem_ack) begin
                        wb_q    <= wb_en_in;
                        mr_q    <= mem_r_en_in;
                        data_q  <= mem_r_en_in ? dmem.dmem_rdata : 32'd0;
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (last_wait) begin
                        buserr_q <= 1'b1;
                        req_q    <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        pc_q   <= 32'd0;
                        alu_q  <= 32'd0;
                        dest_q <= 5'd0;
                        cnt_q  <= (cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_en_out    = wb_q;
    assign mem_r_en_out = mr_q;
    assign pc_out       = pc_q;
    assign alu_res_out  = alu_q;
    assign mem_data_out = data_q;
    assign dest_out     = dest_q;
    assign misalign_err = misalign_q;
    assign bus_err      = buserr_q;

endmodule
